// File: rtl/tick_bcd_counter.sv
// Edge-triggered 4-digit BCD up/down counter with an optional multiplexed
// active-low 7-segment scan, compiled in with TICK_BCD_DISPLAY_EN.
module tick_bcd_counter #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        divided_clk,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        tick,
    output logic        rollover,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    logic        r_prev;
    logic [15:0] r_bcd;
    logic        r_tick;
    logic        r_rollover;
    logic        w_rise;
    logic [15:0] w_next;
    logic        w_wrap;

    assign w_rise = divided_clk & ~r_prev;

    // Carry/borrow ripples through all digits; a carry out of the top digit is the wrap.
    always_comb begin
        logic [3:0] w_dig;
        w_next = r_bcd;
        w_wrap = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            w_dig = r_bcd[4*i +: 4];
            if (w_wrap) begin
                if (up) begin
                    if (w_dig == 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = w_dig + 4'd1;
                        w_wrap           = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_next[4*i +: 4] = w_dig - 4'd1;
                        w_wrap           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_prev <= divided_clk;
        if (rst || clr) begin
            r_bcd      <= '0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (w_rise && en) begin
            r_bcd      <= w_next;
            r_tick     <= 1'b1;
            r_rollover <= w_wrap;
        end else begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end
    end

    assign bcd      = r_bcd;
    assign tick     = r_tick;
    assign rollover = r_rollover;

`ifdef TICK_BCD_DISPLAY_EN
    logic [19:0] r_pre;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == 20'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 20'd1;
        end
    end

    assign w_nib = r_bcd[4*r_idx +: 4];

    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'b1000000;
        end else begin
            r_seg <= w_seg;
        end
    end

    assign an  = ~(4'b0001 << r_idx);
    assign seg = r_seg;
`else
    assign an  = 4'b1111;
    assign seg = 7'b1111111;
`endif

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed self-checking bench for tick_bcd_counter; honours TICK_BCD_DISPLAY_EN.
module tb_tick_bcd_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        divided_clk = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] bcd;
    logic        tick;
    logic        rollover;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    tick_bcd_counter #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .divided_clk (divided_clk),
        .en          (en),
        .up          (up),
        .clr         (clr),
        .bcd         (bcd),
        .tick        (tick),
        .rollover    (rollover),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        divided_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge following the rising sample, when tick is visible.
    task automatic rise_pulse();
        @(negedge clk);
        divided_clk = 1'b1;
        @(negedge clk);
        divided_clk = 1'b0;
    endtask

    task automatic test_reset();
        int nticks;
        @(negedge clk);
        rst = 1'b1;
        divided_clk = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bcd !== 16'h0000 || tick !== 1'b0 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset_state bcd=%h tick=%b roll=%b want 0000/0/0", bcd, tick, rollover);
        end
`ifdef TICK_BCD_DISPLAY_EN
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_display an=%b seg=%b want 1110/1000000", an, seg);
        end
`endif
        en = 1'b1;
        up = 1'b1;
        rst = 1'b0;
        nticks = 0;
        repeat (6) begin
            @(negedge clk);
            if (tick === 1'b1) nticks++;
        end
        checks++;
        if (nticks != 0 || bcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_high_level ticks=%0d bcd=%h want 0/0000", nticks, bcd);
        end
        divided_clk = 1'b0;
        rise_pulse();
        checks++;
        if (tick !== 1'b1 || bcd !== 16'h0001) begin
            errors++;
            $display("FAIL first_tick tick=%b bcd=%h want 1/0001", tick, bcd);
        end
    endtask

    task automatic test_count_up();
        int nticks;
        do_reset();
        en = 1'b1;
        up = 1'b1;
        nticks = 0;
        repeat (10) begin
            @(negedge clk); divided_clk = 1'b1; if (tick === 1'b1) nticks++;
            @(negedge clk);                     if (tick === 1'b1) nticks++;
            @(negedge clk); divided_clk = 1'b0; if (tick === 1'b1) nticks++;
            @(negedge clk);                     if (tick === 1'b1) nticks++;
        end
        @(negedge clk);
        if (tick === 1'b1) nticks++;
        checks++;
        if (bcd !== 16'h0010) begin
            errors++;
            $display("FAIL count_up_value bcd=%h want 0010", bcd);
        end
        checks++;
        if (nticks != 10) begin
            errors++;
            $display("FAIL count_up_ticks got=%0d want 10", nticks);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        en = 1'b1;
        up = 1'b0;
        rise_pulse();
        checks++;
        if (bcd !== 16'h9999 || rollover !== 1'b1 || tick !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap bcd=%h roll=%b tick=%b want 9999/1/1", bcd, rollover, tick);
        end
        @(negedge clk);
        checks++;
        if (rollover !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap_pulse roll=%b tick=%b want 0/0", rollover, tick);
        end
        up = 1'b1;
        rise_pulse();
        checks++;
        if (bcd !== 16'h0000 || rollover !== 1'b1 || tick !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap bcd=%h roll=%b tick=%b want 0000/1/1", bcd, rollover, tick);
        end
        @(negedge clk);
        checks++;
        if (rollover !== 1'b0 || tick !== 1'b0 || bcd !== 16'h0000) begin
            errors++;
            $display("FAIL up_wrap_pulse roll=%b tick=%b bcd=%h want 0/0/0000", rollover, tick, bcd);
        end
    endtask

    task automatic test_borrow();
        do_reset();
        en = 1'b1;
        up = 1'b1;
        repeat (100) rise_pulse();
        checks++;
        if (bcd !== 16'h0100) begin
            errors++;
            $display("FAIL carry_100 bcd=%h want 0100", bcd);
        end
        up = 1'b0;
        rise_pulse();
        checks++;
        if (bcd !== 16'h0099 || rollover !== 1'b0 || tick !== 1'b1) begin
            errors++;
            $display("FAIL borrow bcd=%h roll=%b tick=%b want 0099/0/1", bcd, rollover, tick);
        end
    endtask

    task automatic test_clr_enable();
        int nticks;
        do_reset();
        en = 1'b1;
        up = 1'b1;
        repeat (42) rise_pulse();
        checks++;
        if (bcd !== 16'h0042) begin
            errors++;
            $display("FAIL preload_42 bcd=%h want 0042", bcd);
        end
        @(negedge clk);
        divided_clk = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bcd !== 16'h0000 || tick !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_rise bcd=%h tick=%b want 0000/0", bcd, tick);
        end
        clr = 1'b0;
        divided_clk = 1'b0;
        repeat (5) rise_pulse();
        en = 1'b0;
        nticks = 0;
        repeat (3) begin
            rise_pulse();
            if (tick === 1'b1) nticks++;
        end
        checks++;
        if (bcd !== 16'h0005 || nticks != 0) begin
            errors++;
            $display("FAIL en_low bcd=%h ticks=%0d want 0005/0", bcd, nticks);
        end
        en = 1'b1;
        rise_pulse();
        checks++;
        if (bcd !== 16'h0006) begin
            errors++;
            $display("FAIL not_queued bcd=%h want 0006", bcd);
        end
        repeat (3) rise_pulse();
        @(negedge clk);
        rst = 1'b1;
        divided_clk = 1'b1;
        @(negedge clk);
        checks++;
        if (bcd !== 16'h0000 || tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset bcd=%h tick=%b want 0000/0", bcd, tick);
        end
        rst = 1'b0;
        divided_clk = 1'b0;
    endtask

    task automatic test_display();
`ifdef TICK_BCD_DISPLAY_EN
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        logic [3:0] prev_an;
        bit found;
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100;
        exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001;
        do_reset();
        en = 1'b1;
        up = 1'b1;
        repeat (1234) rise_pulse();
        en = 1'b0;
        checks++;
        if (bcd !== 16'h1234) begin
            errors++;
            $display("FAIL preload_1234 bcd=%h want 1234", bcd);
        end
        found = 1'b0;
        prev_an = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
            prev_an = an;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_sync an=%b want transition to 1110", an);
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (an !== exp_an[s]) begin
                errors++;
                $display("FAIL scan_an slot=%0d an=%b want %b", s, an, exp_an[s]);
            end
            @(negedge clk);
            checks++;
            if (seg !== exp_seg[s] || an !== exp_an[s]) begin
                errors++;
                $display("FAIL scan_seg slot=%0d seg=%b an=%b want %b/%b", s, seg, an, exp_seg[s], exp_an[s]);
            end
            repeat (3) @(negedge clk);
        end
`else
        int bad;
        bad = 0;
        en = 1'b1;
        repeat (10) begin
            rise_pulse();
            if (an !== 4'b1111 || seg !== 7'b1111111) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL display_off bad=%0d an=%b seg=%b want 1111/1111111", bad, an, seg);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_rollover();
        test_borrow();
        test_clr_enable();
        test_display();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
